// File: rtl/sda_kernel_run_sequencer.sv
// Run sequencer for an accelerator action core: AP_CTRL / GIE / IER / ISR register
// block, the IDLE -> GO -> RUN handshake FSM and a saturating run-cycle counter.
module sda_kernel_run_sequencer #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        reg_req,
    output logic        reg_ack,
    input  logic        reg_write_en,
    input  logic [2:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        action_go_valid,
    input  logic        action_go_holdoff,
    input  logic        action_done_valid,
    output logic        action_done_stop,
    output logic        ap_interrupt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GO   = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    localparam logic [2:0] ADDR_AP_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_GIE        = 3'd1;
    localparam logic [2:0] ADDR_IER        = 3'd2;
    localparam logic [2:0] ADDR_ISR        = 3'd3;
    localparam logic [2:0] ADDR_RUN_CYCLES = 3'd4;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic                 ap_start_q, ap_start_d;
    logic                 ap_done_q, ap_done_d;
    logic                 ap_ready_q, ap_ready_d;
    logic                 auto_restart_q, auto_restart_d;
    logic                 gie_q, gie_d;
    logic [1:0]           ier_q, ier_d;
    logic [1:0]           isr_q, isr_d;
    logic [CNT_WIDTH-1:0] run_cycles_q, run_cycles_d;
    logic                 reg_ack_q, reg_ack_d;
    logic [31:0]          reg_rdata_q, reg_rdata_d;
    logic                 go_valid_q, go_valid_d;
    logic                 done_stop_q, done_stop_d;
    logic                 irq_q, irq_d;

    logic        access, rd_access, wr_access;
    logic        go_accept, run_done;
    logic [31:0] rd_word;
    logic [28:0] wdata_unused;

    // A request still high during its own ack cycle must not start a second access.
    always_comb begin
        access       = reg_req && !reg_ack_q;
        rd_access    = access && !reg_write_en;
        wr_access    = access && reg_write_en;
        go_accept    = (state_q == S_GO) && !action_go_holdoff;
        run_done     = (state_q == S_RUN) && action_done_valid;
        wdata_unused = {reg_wdata[31:8], reg_wdata[6:2]};

        rd_word = '0;
        case (reg_addr)
            ADDR_AP_CTRL:    rd_word = {24'd0, auto_restart_q, 3'd0, ap_ready_q,
                                        (state_q == S_IDLE), ap_done_q, ap_start_q};
            ADDR_GIE:        rd_word = {31'd0, gie_q};
            ADDR_IER:        rd_word = {30'd0, ier_q};
            ADDR_ISR:        rd_word = {30'd0, isr_q};
            ADDR_RUN_CYCLES: rd_word = 32'(run_cycles_q);
            default:         rd_word = '0;
        endcase
    end

    // NOTE: every signal gets its hold value first so no path through this block
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d        = state_q;
        ap_start_d     = ap_start_q;
        ap_done_d      = ap_done_q;
        ap_ready_d     = ap_ready_q;
        auto_restart_d = auto_restart_q;
        gie_d          = gie_q;
        ier_d          = ier_q;
        isr_d          = isr_q;
        run_cycles_d   = run_cycles_q;

        case (state_q)
            S_IDLE: begin
                if (ap_start_q) state_d = S_GO;
            end
            S_GO: begin
                if (go_accept) begin
                    state_d      = S_RUN;
                    run_cycles_d = '0;
                    if (!auto_restart_q) ap_start_d = 1'b0;
                end
            end
            S_RUN: begin
                if (run_cycles_q != CNT_MAX) run_cycles_d = run_cycles_q + CNT_WIDTH'(1);
                if (run_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Order matters: clears and toggles first, hardware set events last so they win.
        if (rd_access && reg_addr == ADDR_AP_CTRL) begin
            ap_done_d  = 1'b0;
            ap_ready_d = 1'b0;
        end

        if (wr_access) begin
            case (reg_addr)
                ADDR_AP_CTRL: begin
                    if (reg_wdata[0]) ap_start_d = 1'b1;
                    auto_restart_d = reg_wdata[7];
                end
                ADDR_GIE: gie_d = reg_wdata[0];
                ADDR_IER: ier_d = reg_wdata[1:0];
                ADDR_ISR: isr_d = isr_q ^ reg_wdata[1:0];
                default: ;
            endcase
        end

        if (go_accept) begin
            ap_ready_d = 1'b1;
            isr_d[1]   = 1'b1;
        end
        if (run_done) begin
            ap_done_d = 1'b1;
            isr_d[0]  = 1'b1;
        end
    end

    always_comb begin
        reg_ack_d   = access;
        reg_rdata_d = rd_access ? rd_word : '0;
        go_valid_d  = (state_d == S_GO);
        done_stop_d = (state_d != S_RUN);
        irq_d       = gie_q & (|(isr_q & ier_q));
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q        <= S_IDLE;
            ap_start_q     <= 1'b0;
            ap_done_q      <= 1'b0;
            ap_ready_q     <= 1'b0;
            auto_restart_q <= 1'b0;
            gie_q          <= 1'b0;
            ier_q          <= '0;
            isr_q          <= '0;
            run_cycles_q   <= '0;
            reg_ack_q      <= 1'b0;
            reg_rdata_q    <= '0;
            go_valid_q     <= 1'b0;
            done_stop_q    <= 1'b1;
            irq_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            ap_start_q     <= ap_start_d;
            ap_done_q      <= ap_done_d;
            ap_ready_q     <= ap_ready_d;
            auto_restart_q <= auto_restart_d;
            gie_q          <= gie_d;
            ier_q          <= ier_d;
            isr_q          <= isr_d;
            run_cycles_q   <= run_cycles_d;
            reg_ack_q      <= reg_ack_d;
            reg_rdata_q    <= reg_rdata_d;
            go_valid_q     <= go_valid_d;
            done_stop_q    <= done_stop_d;
            irq_q          <= irq_d;
        end
    end

    assign reg_ack          = reg_ack_q;
    assign reg_rdata        = reg_rdata_q;
    assign action_go_valid  = go_valid_q;
    assign action_done_stop = done_stop_q;
    assign ap_interrupt     = irq_q;

endmodule

// File: doc/sda_kernel_run_sequencer.md
SDA_KERNEL_RUN_SEQUENCER -- requirements
Module: sda_kernel_run_sequencer

Interface
REQ-001 Parameter: CNT_WIDTH, default 32, width of run cycle counter (1..32); register reads zero-extend to 32 bits.
REQ-002 ap_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 ap_rst_n  in  1  asynchronous, active-low reset.
REQ-004 reg_req  in  1  register access request; held until reg_ack.
REQ-005 reg_ack  out  1  single-cycle access acknowledge.
REQ-006 reg_write_en  in  1  1 = write, 0 = read; qualified by reg_req.
REQ-007 reg_addr  in  3  word index: 0 AP_CTRL, 1 GIE, 2 IER, 3 ISR, 4 RUN_CYCLES, 5-7 reserved.
REQ-008 reg_wdata  in  32  write data.
REQ-009 reg_rdata  out  32  read data, valid only while reg_ack=1, else 0.
REQ-010 action_go_valid  out  1  run request to action core.
REQ-011 action_go_holdoff  in  1  action core not ready to accept go.
REQ-012 action_done_valid  in  1  action core completion.
REQ-013 action_done_stop  out  1  back-pressure on done; 0 only in RUN.
REQ-014 ap_interrupt  out  1  registered level interrupt to host.

Function
REQ-015 Access occurs on an edge where reg_req=1 and reg_ack=0; reg_ack=1 the following cycle; reg_req=1 while reg_ack=1 SHALL NOT start a second access.
REQ-016 AP_CTRL bits: [0] ap_start RW, [1] ap_done RO clear-on-read, [2] ap_idle RO, [3] ap_ready RO clear-on-read, [7] auto_restart RW; other bits read 0.
REQ-017 Writing AP_CTRL with wdata[0]=1 sets ap_start; writing 0 to bit 0 SHALL NOT clear it; bit 7 written directly.
REQ-018 GIE bit0 RW; IER bits[1:0] RW; ISR bits[1:0] toggle-on-write (wdata bit 1 inverts the bit); unused bits read 0.
REQ-019 RUN_CYCLES read-only; writes to RUN_CYCLES and reserved addresses are acknowledged and ignored; reserved reads return 0.
REQ-020 FSM states IDLE, GO, RUN; ap_idle = (state==IDLE).
REQ-021 IDLE: ap_start=1 -> GO next edge.
REQ-022 GO: action_go_valid=1; go accepted on edge with action_go_holdoff=0 -> RUN; same edge sets ap_ready and ISR[1], clears ap_start unless auto_restart=1, and loads RUN_CYCLES to 0.
REQ-023 RUN: action_done_stop=0; RUN_CYCLES increments by 1 per cycle, saturating at 2^CNT_WIDTH-1.
REQ-024 RUN: action_done_valid=1 -> IDLE next edge; same edge sets ap_done and ISR[0]; RUN_CYCLES holds until next go accepted.
REQ-025 action_done_valid outside RUN is ignored; action_go_valid=0 outside GO.
REQ-026 auto_restart=1 with ap_start=1 on done: IDLE for exactly one cycle, then GO.
REQ-027 Simultaneous set event and clear-on-read (ap_done, ap_ready) or ISR toggle: set wins, bit reads 1 after the edge; the read itself returns pre-edge value.
REQ-028 Write of ap_start=1 in GO or RUN is latched and starts the next run after completion.
REQ-029 ap_interrupt registered: next-cycle value = GIE[0] & |(ISR[1:0] & IER[1:0]).

Reset
REQ-030 On ap_rst_n=0, immediately: state IDLE, ap_start/ap_done/ap_ready/auto_restart/GIE/IER/ISR = 0, RUN_CYCLES = 0, reg_ack=0, reg_rdata=0, action_go_valid=0, action_done_stop=1, ap_interrupt=0.
REQ-031 Reset asserted in GO or RUN abandons the run; no ap_done/ISR set; first accepted access after release observes AP_CTRL=0x04.

Verification
REQ-032 Reset release, read AP_CTRL -> 0x00000004; read ISR -> 0; action_done_stop=1.
REQ-033 Write AP_CTRL=1, holdoff=1 for 3 cycles then 0, done after 10 RUN cycles -> go_valid high 4 cycles, AP_CTRL read 0x0E then 0x04, RUN_CYCLES=10.
REQ-034 GIE=1, IER=1, complete run -> ap_interrupt=1 one cycle after done; write ISR=1 -> ap_interrupt=0 one cycle later; IER=2 run -> interrupt from ready only.
REQ-035 AP_CTRL=0x81 -> back-to-back runs with one IDLE cycle between; write 0x00 -> current run completes, no further go.
REQ-036 Read AP_CTRL on the done edge -> returns ap_done=0, subsequent read returns ap_done=1; ap_rst_n low mid-RUN -> go_valid=0, done_stop=1 asynchronously.
